// File: rtl/multiplication_processor.sv
// multiplication_processor: sequential shift-and-add unsigned multiplier, one partial product per clock
module multiplication_processor #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic               rdy,
    output logic [2*WIDTH-1:0] out,
    output logic               out_rdy,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [2*WIDTH-1:0] r_acc, r_out, w_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_sum;
    logic               w_last;
    assign w_last  = r_cnt == CW'(1);
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc   = {w_sum, r_acc[WIDTH-1:1]};
    assign out     = r_out;
    assign out_rdy = r_state == DONE;
    assign busy    = r_state != IDLE;
    // Next state: capture on rdy in IDLE, finish on the last iteration, unused encodings fall back to IDLE
    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE) ? (rdy ? MULT : IDLE) :
                 (r_state == MULT) ? (w_last ? DONE : MULT) : IDLE;
    end
    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Datapath: operand capture, add-and-shift iterations, result latch on the final iteration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
        end else if (r_state == IDLE && rdy) begin
            r_mcand  <= data1;
            r_mplier <= data2;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
        end else if (r_state == MULT) begin
            r_acc    <= w_acc;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last) r_out <= w_acc;
        end
    end
endmodule
